// File: rtl/mem_pkg.sv
// Shared encodings and payload types for the data-memory responder.
package mem_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Width of the wait-state counter (WAIT_CYC range 0..15)
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Request captured at acceptance
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        unsig;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Load/store port between the core (master) and the memory responder (slave).
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsig;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsig, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsig, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane steering: store enables/replication, load extraction/extension, alignment check.
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        unsig,
    input  logic [31:0] raw,
    input  logic [31:0] wdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c,
    output logic        misalign_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and half out of the stored word
    always_comb begin
        byte_sel = raw[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? raw[31:16] : raw[15:0];
    end

    // Per-size lane enables, write replication and load extension
    always_comb begin
        be_c       = 4'b0000;
        wdata_c    = wdata;
        rdata_c    = 32'd0;
        misalign_c = 1'b0;
        case (size)
            SZ_BYTE: begin
                be_c    = 4'b0001 << lane;
                wdata_c = {4{wdata[7:0]}};
                rdata_c = {{24{~unsig & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be_c       = lane[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{wdata[15:0]}};
                rdata_c    = {{16{~unsig & half_sel[15]}}, half_sel};
                misalign_c = lane[0];
            end
            SZ_WORD: begin
                be_c       = 4'b1111;
                rdata_c    = raw;
                misalign_c = (lane != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, programmable wait states, word array storage.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    state_e             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    mem_req_t           req_q, req_nx;
    logic               ready_q, ready_nx;
    logic               valid_q, valid_nx;
    logic [31:0]        rdata_q, rdata_nx;
    logic               err_q, err_nx;

    logic               acc_c;
    logic [ADDR_W-1:0]  idx;
    logic [31:0]        raw;
    logic [3:0]         be;
    logic [31:0]        wdata_rep;
    logic [31:0]        rdata_ext;
    logic               misalign;
    logic               err_c;

    assign idx = req_q.addr[ADDR_W+1:2];
    assign raw = mem[idx];

    mem_lane_fmt u_fmt (
        .lane       (req_q.addr[1:0]),
        .size       (req_q.size),
        .unsig      (req_q.unsig),
        .raw        (raw),
        .wdata      (req_q.wdata),
        .be_c       (be),
        .wdata_c    (wdata_rep),
        .rdata_c    (rdata_ext),
        .misalign_c (misalign)
    );

    // Reject misaligned, out-of-range and reserved-size accesses
    always_comb begin
        err_c = misalign
              || ((req_q.addr >> (ADDR_W + 2)) != 32'd0)
              || (req_q.size == SZ_RSVD);
    end

    // State, latched request and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            req_q   <= req_nx;
            ready_q <= ready_nx;
            valid_q <= valid_nx;
            rdata_q <= rdata_nx;
            err_q   <= err_nx;
        end
    end

    // Next state; the counter holds cycles remaining before the access cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = req_q;
        rdata_nx = rdata_q;
        err_nx   = err_q;
        acc_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    req_nx.we    = bus.req_we;
                    req_nx.addr  = bus.req_addr;
                    req_nx.wdata = bus.req_wdata;
                    req_nx.size  = bus.req_size;
                    req_nx.unsig = bus.req_unsig;
                    cnt_nx       = CNT_W'(WAIT_CYC);
                    state_nx     = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    acc_c    = 1'b1;
                    err_nx   = err_c;
                    rdata_nx = (err_c || req_q.we) ? 32'd0 : rdata_ext;
                    state_nx = RESP;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        ready_nx = (state_nx == IDLE);
        valid_nx = (state_nx == RESP);
    end

    // Byte-enabled store at the access edge; contents survive reset
    always_ff @(posedge clk) begin
        if (acc_c && req_q.we && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYC=1 and 0) against a byte-addressed model.
module tb_mem_responder;

    localparam int ADDR_W    = 6;
    localparam int MEM_BYTES = 1 << (ADDR_W + 2);

    logic clk;
    logic rst        [2];
    logic req_valid  [2];
    logic req_ready  [2];
    logic req_we     [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  req_size  [2];
    logic req_unsig  [2];
    logic resp_valid [2];
    logic resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic resp_err   [2];

    int wc [2] = '{1, 0};

    for (genvar g = 0; g < 2; g++) begin : gu
        mem_responder_if bus ();
        assign bus.req_valid  = req_valid[g];
        assign bus.req_we     = req_we[g];
        assign bus.req_addr   = req_addr[g];
        assign bus.req_wdata  = req_wdata[g];
        assign bus.req_size   = req_size[g];
        assign bus.req_unsig  = req_unsig[g];
        assign bus.resp_ready = resp_ready[g];
        assign req_ready[g]   = bus.req_ready;
        assign resp_valid[g]  = bus.resp_valid;
        assign resp_rdata[g]  = bus.resp_rdata;
        assign resp_err[g]    = bus.resp_err;

        mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYC((g == 0) ? 1 : 0)) u_dut (
            .clk (clk),
            .rst (rst[g]),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem_m [2][MEM_BYTES];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: little-endian bytes, natural alignment required
    task automatic model(input int u, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic unsig,
                         output logic [31:0] d, output logic e);
        int n;
        n = 1 << size;
        e = (size == 2'd3) || (addr >= 32'(MEM_BYTES)) || ((addr & 32'(n - 1)) != 32'd0);
        d = 32'd0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                if (we) mem_m[u][int'(addr) + i] = wdata[8*i +: 8];
                else    d = d | (32'(mem_m[u][int'(addr) + i]) << (8 * i));
            end
            if (!we && !unsig && n < 4 && d[8*n-1]) d = d | (32'hFFFF_FFFF << (8 * n));
        end
    endtask

    // One full request/response exchange with latency, stability and retire checks
    task automatic txn(input int u, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic unsig,
                       input int hold, input string tag,
                       output logic [31:0] od, output logic oe);
        logic [31:0] ed;
        logic        ee;
        int          lat;
        model(u, we, addr, wdata, size, unsig, ed, ee);
        chk({tag, "/idle"}, 32'(req_ready[u]), 32'd1);
        req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr;
        req_wdata[u] = wdata; req_size[u] = size; req_unsig[u] = unsig;
        @(posedge clk); #1;
        req_valid[u] = 1'($urandom_range(0, 1));
        req_we[u]    = 1'($urandom_range(0, 1));
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
        req_size[u]  = 2'($urandom_range(0, 3));
        req_unsig[u] = 1'($urandom_range(0, 1));
        lat = 0;
        while (resp_valid[u] !== 1'b1 && lat < 40) begin
            chk({tag, "/busy"}, 32'(req_ready[u]), 32'd0);
            @(posedge clk); #1;
            req_valid[u] = 1'($urandom_range(0, 1));
            lat++;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(wc[u] + 1));
        od = resp_rdata[u];
        oe = resp_err[u];
        if (resp_valid[u] !== 1'b1) begin
            req_valid[u] = 1'b0;
            return;
        end
        chk({tag, "/rdata"}, resp_rdata[u], ed);
        chk({tag, "/err"}, 32'(resp_err[u]), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req_valid[u] = 1'($urandom_range(0, 1));
            chk({tag, "/hv"}, 32'(resp_valid[u]), 32'd1);
            chk({tag, "/hd"}, resp_rdata[u], ed);
            chk({tag, "/he"}, 32'(resp_err[u]), 32'(ee));
            chk({tag, "/hr"}, 32'(req_ready[u]), 32'd0);
        end
        resp_ready[u] = 1'b1;
        req_valid[u]  = 1'b0;
        @(posedge clk); #1;
        resp_ready[u] = 1'b0;
        chk({tag, "/ret_v"}, 32'(resp_valid[u]), 32'd0);
        chk({tag, "/ret_r"}, 32'(req_ready[u]), 32'd1);
    endtask

    logic [31:0] od;
    logic        oe;

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = 32'd0;
            req_wdata[u] = 32'd0; req_size[u] = 2'd0; req_unsig[u] = 1'b0; resp_ready[u] = 1'b0;
        end
        #12;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst%0d/ready", u), 32'(req_ready[u]), 32'd1);
            chk($sformatf("rst%0d/valid", u), 32'(resp_valid[u]), 32'd0);
            chk($sformatf("rst%0d/rdata", u), resp_rdata[u], 32'd0);
            chk($sformatf("rst%0d/err", u), 32'(resp_err[u]), 32'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Give every word a known value
        for (int u = 0; u < 2; u++)
            for (int w = 0; w < MEM_BYTES / 4; w++)
                txn(u, 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0, "fill", od, oe);

        // Directed cases on the WAIT_CYC=1 instance
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, "st_w10", od, oe);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "ld_w10", od, oe);
        chk("ld_w10/lit", od, 32'hDEADBEEF);
        txn(0, 1'b1, 32'h13, 32'h80, 2'd0, 1'b0, 0, "st_b13", od, oe);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "ld_w10b", od, oe);
        chk("ld_w10b/lit", od, 32'h80ADBEEF);
        txn(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, "ld_b13s", od, oe);
        chk("ld_b13s/lit", od, 32'hFFFFFF80);
        txn(0, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, "ld_b13u", od, oe);
        chk("ld_b13u/lit", od, 32'h00000080);
        txn(0, 1'b1, 32'h20, 32'h11223344, 2'd2, 1'b0, 0, "st_w20", od, oe);
        txn(0, 1'b1, 32'h22, 32'h1234, 2'd1, 1'b0, 0, "st_h22", od, oe);
        txn(0, 1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 0, "ld_h22", od, oe);
        chk("ld_h22/lit", od, 32'h00001234);
        txn(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, "ld_w20", od, oe);
        chk("ld_w20/lit", od, 32'h12343344);
        txn(0, 1'b0, 32'h21, 32'h0, 2'd1, 1'b0, 0, "mis_h21", od, oe);
        chk("mis_h21/lit", 32'(oe), 32'd1);
        txn(0, 1'b1, 32'h12, 32'h55555555, 2'd2, 1'b0, 0, "mis_w12", od, oe);
        chk("mis_w12/lit", 32'(oe), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "ld_w10c", od, oe);
        chk("ld_w10c/lit", od, 32'h80ADBEEF);
        txn(0, 1'b0, 32'h14, 32'h0, 2'd3, 1'b0, 0, "rsvd", od, oe);
        chk("rsvd/lit", 32'(oe), 32'd1);
        txn(0, 1'b0, 32'(MEM_BYTES), 32'h0, 2'd0, 1'b0, 0, "oor", od, oe);
        chk("oor/lit", 32'(oe), 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, "bp_w1", od, oe);
        txn(1, 1'b0, 32'h08, 32'h0, 2'd2, 1'b0, 5, "bp_w0", od, oe);

        // Reset during WAIT drops a pending store
        txn(0, 1'b1, 32'h40, 32'h11111111, 2'd2, 1'b0, 0, "st_w40", od, oe);
        txn(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "pre_rst", od, oe);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h40;
        req_wdata[0] = 32'hCAFEF00D; req_size[0] = 2'd2; req_unsig[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        chk("midrst/acc", 32'(req_ready[0]), 32'd0);
        #2 rst[0] = 1'b1;
        #1;
        chk("midrst/ready", 32'(req_ready[0]), 32'd1);
        chk("midrst/valid", 32'(resp_valid[0]), 32'd0);
        chk("midrst/rdata", resp_rdata[0], 32'd0);
        chk("midrst/err", 32'(resp_err[0]), 32'd0);
        @(negedge clk); @(negedge clk);
        rst[0] = 1'b0;
        txn(0, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, "ld_w40", od, oe);
        chk("ld_w40/lit", od, 32'h11111111);

        // Randomized traffic on both instances
        for (int k = 0; k < 300; k++) begin
            int          u;
            int          r;
            logic [1:0]  sz;
            logic [31:0] a;
            u  = $urandom_range(0, 1);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r  = $urandom_range(0, 15);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(MEM_BYTES) + 32'($urandom_range(0, 15));
            else             a = 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 2) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            txn(u, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $sformatf("rnd%0d", k), od, oe);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
